serial_frame_rx: RTL

Serial-to-parallel frame receiver: the receiving end of the team's shift-register serial link. It samples a framed bit stream (start bit, DATA_W data bits MSB first, stop bit) one bit per enable strobe, assembles the word, and presents it on a parallel port through a one-entry valid/ready holding register. It also flags framing errors and overruns. It sits between the serial line driven by a ShiftRegister `Out` and the parallel consumer logic.

---
 rtl/serial_frame_rx.sv | 115 +++++++++++
 1 files changed

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits MSB first, stop bit.
// Ports: Clk, Reset (sync, high), In/En serial input with bit strobe,
//   DataOut/Valid/Ready one-entry output register, Busy, FrameErr (pulse),
//   Overrun (sticky, cleared by ClrErr).
module serial_frame_rx #(
    parameter int DATA_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              In,
    input  logic              En,
    input  logic              Ready,
    input  logic              ClrErr,
    output logic [DATA_W-1:0] DataOut,
    output logic              Valid,
    output logic              Busy,
    output logic              FrameErr,
    output logic              Overrun
);

    localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic              done;
    logic              ferr_n;
    logic              load;
    logic              ovr;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sh    <= sh_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        done    = 1'b0;
        ferr_n  = 1'b0;
        if (En) begin
            unique case (state)
                IDLE: begin
                    if (!In) begin
                        state_n = DATA;
                        cnt_n   = '0;
                    end
                end
                DATA: begin
                    sh_n  = {sh[DATA_W-2:0], In};
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(DATA_W - 1)) begin
                        state_n = STOP;
                    end
                end
                STOP: begin
                    // A low stop bit returns to IDLE; it is never
                    // taken as the start of the next frame.
                    state_n = IDLE;
                    if (In) begin
                        done = 1'b1;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // A word completing while the holder is being drained replaces it.
    assign load = done && (!Valid || Ready);
    assign ovr  = done && Valid && !Ready;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            DataOut  <= '0;
            Valid    <= 1'b0;
            FrameErr <= 1'b0;
            Overrun  <= 1'b0;
        end else begin
            FrameErr <= ferr_n;
            if (load) begin
                DataOut <= sh;
                Valid   <= 1'b1;
            end else if (Valid && Ready) begin
                Valid <= 1'b0;
            end
            if (ovr) begin
                Overrun <= 1'b1;
            end else if (ClrErr) begin
                Overrun <= 1'b0;
            end
        end
    end

    assign Busy = (state != IDLE);

endmodule
